// File: rtl/minesweeper_pkg.sv
// Shared minesweeper definitions: command opcodes, engine FSM states and
// the 8-way neighbour offset table used by the flood-fill scan.
package minesweeper_pkg;

  localparam logic OP_FLAG   = 1'b0;
  localparam logic OP_REVEAL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_SCAN = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  // Row offset for scan direction 0..7 (N, NE, E, SE, S, SW, W, NW),
  // two's complement: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1.
  function automatic logic [1:0] dir_drow(input logic [2:0] dir);
    logic [1:0] d;
    case (dir)
      3'd0, 3'd1, 3'd7: d = 2'b11;
      3'd3, 3'd4, 3'd5: d = 2'b01;
      default:          d = 2'b00;
    endcase
    return d;
  endfunction

  // Column offset for scan direction 0..7, same encoding as dir_drow.
  function automatic logic [1:0] dir_dcol(input logic [2:0] dir);
    logic [1:0] d;
    case (dir)
      3'd1, 3'd2, 3'd3: d = 2'b01;
      3'd5, 3'd6, 3'd7: d = 2'b11;
      default:          d = 2'b00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tile_reveal_engine_stack.sv
// LIFO of packed {row,col} coordinates for the flood-fill worklist.
// Push and pop are never requested in the same cycle by the engine.
module tile_stack #(
  parameter int DEPTH = 25,
  parameter int W     = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_top,
  output logic         o_empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PW-1:0]           r_ptr;

  assign o_empty = (r_ptr == '0);
  assign o_top   = r_mem[AW'(r_ptr - PW'(1))];

  // Stack pointer: counts stored entries, cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PW'(1);
    end else if (i_pop) begin
      r_ptr <= r_ptr - PW'(1);
    end
  end

  // Entry storage: no reset needed, only slots below the pointer are read.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[AW'(r_ptr)] <= i_push_data;
  end

endmodule

// File: rtl/tile_reveal_engine.sv
// Tile state engine: holds flagged/revealed bits, executes FLAG/REVEAL
// commands and runs an autonomous flood-fill from zero-count tiles.
module tile_reveal_engine
  import minesweeper_pkg::*;
#(
  parameter  int GRID_W      = 5,
  parameter  int GRID_H      = 5,
  parameter  int NUM_MINES   = 4,
  localparam int TOTAL_TILES = GRID_W * GRID_H,
  localparam int RW          = $clog2(GRID_H),
  localparam int CW          = $clog2(GRID_W),
  localparam int CNTW        = $clog2(TOTAL_TILES + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_op,
  input  logic [RW-1:0]            i_cmd_row,
  input  logic [CW-1:0]            i_cmd_col,
  input  logic [TOTAL_TILES-1:0]   i_mine_map,
  input  logic [4*TOTAL_TILES-1:0] i_adj_count,
  output logic [TOTAL_TILES-1:0]   o_flagged,
  output logic [TOTAL_TILES-1:0]   o_revealed,
  output logic [CNTW-1:0]          o_flag_count,
  output logic [CNTW-1:0]          o_reveal_count,
  output logic                     o_busy,
  output logic                     o_lost,
  output logic                     o_won
);

  localparam int             IW      = $clog2(TOTAL_TILES);
  localparam logic [RW:0]    ROWS    = (RW + 1)'(GRID_H);
  localparam logic [CW:0]    COLS    = (CW + 1)'(GRID_W);
  localparam logic [IW-1:0]  W_IDX   = IW'(GRID_W);
  localparam logic [CNTW-1:0] WIN_CNT = CNTW'(TOTAL_TILES - NUM_MINES);

  state_t                 r_state, w_next;
  logic [TOTAL_TILES-1:0] r_flagged, r_revealed;
  logic [CNTW-1:0]        r_flag_count, r_reveal_count;
  logic                   r_lost, r_won;
  logic [RW-1:0]          r_cur_row;
  logic [CW-1:0]          r_cur_col;
  logic [2:0]             r_dir;

  // command decode
  logic          w_cmd_fire, w_cmd_inrange, w_cmd_zero;
  logic [IW-1:0] w_cmd_idx;

  // neighbour under scan
  logic [1:0]    w_drow, w_dcol;
  logic [RW:0]   w_drow_x, w_nr;
  logic [CW:0]   w_dcol_x, w_nc;
  logic [IW-1:0] w_nb_idx;
  logic          w_nb_inb, w_nb_ok, w_nb_zero;

  // control strobes from the FSM
  logic             w_push, w_pop, w_empty;
  logic [RW+CW-1:0] w_push_data, w_top;
  logic             w_rev_en, w_flag_en, w_lost_set;
  logic [IW-1:0]    w_rev_idx;

  assign o_cmd_ready   = (r_state == ST_IDLE) && !r_lost && !r_won;
  assign w_cmd_fire    = i_cmd_valid && o_cmd_ready;
  assign w_cmd_inrange = ({1'b0, i_cmd_row} < ROWS) && ({1'b0, i_cmd_col} < COLS);
  assign w_cmd_idx     = IW'(i_cmd_row) * W_IDX + IW'(i_cmd_col);
  assign w_cmd_zero    = (i_adj_count[{w_cmd_idx, 2'b00} +: 4] == 4'd0);

  // Neighbour coordinates are one bit wider so that -1 wraps to a value
  // that fails the unsigned bound check, covering both edges at once.
  assign w_drow    = dir_drow(r_dir);
  assign w_dcol    = dir_dcol(r_dir);
  assign w_drow_x  = (RW + 1)'($signed(w_drow));
  assign w_dcol_x  = (CW + 1)'($signed(w_dcol));
  assign w_nr      = {1'b0, r_cur_row} + w_drow_x;
  assign w_nc      = {1'b0, r_cur_col} + w_dcol_x;
  assign w_nb_inb  = (w_nr < ROWS) && (w_nc < COLS);
  assign w_nb_idx  = IW'(w_nr[RW-1:0]) * W_IDX + IW'(w_nc[CW-1:0]);
  assign w_nb_ok   = w_nb_inb && !r_revealed[w_nb_idx] && !r_flagged[w_nb_idx];
  assign w_nb_zero = (i_adj_count[{w_nb_idx, 2'b00} +: 4] == 4'd0);

  tile_stack #(
    .DEPTH (TOTAL_TILES),
    .W     (RW + CW)
  ) u_stack (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_top       (w_top),
    .o_empty     (w_empty)
  );

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and datapath strobes; tiles are marked revealed at push
  // time so no tile ever enters the stack twice.
  always_comb begin
    w_next      = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_push_data = '0;
    w_rev_en    = 1'b0;
    w_rev_idx   = '0;
    w_flag_en   = 1'b0;
    w_lost_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_won) begin
          w_next = ST_OVER;
        end else if (w_cmd_fire && w_cmd_inrange) begin
          case (i_cmd_op)
            OP_FLAG:   w_flag_en = !r_revealed[w_cmd_idx];
            OP_REVEAL: begin
              if (!r_revealed[w_cmd_idx] && !r_flagged[w_cmd_idx]) begin
                w_rev_en  = 1'b1;
                w_rev_idx = w_cmd_idx;
                if (i_mine_map[w_cmd_idx]) begin
                  w_lost_set = 1'b1;
                  w_next     = ST_OVER;
                end else if (w_cmd_zero) begin
                  w_push      = 1'b1;
                  w_push_data = {i_cmd_row, i_cmd_col};
                  w_next      = ST_POP;
                end
              end
            end
            default: ;
          endcase
        end
      end
      ST_POP: begin
        w_pop  = 1'b1;
        w_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_nb_ok) begin
          w_rev_en  = 1'b1;
          w_rev_idx = w_nb_idx;
          if (w_nb_zero) begin
            w_push      = 1'b1;
            w_push_data = {w_nr[RW-1:0], w_nc[CW-1:0]};
          end
        end
        if (r_dir == 3'd7) w_next = (!w_empty || w_push) ? ST_POP : ST_IDLE;
      end
      default: w_next = ST_OVER;
    endcase
  end

  // Tile state, counters, sticky status and the scan cursor.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_flagged      <= '0;
      r_revealed     <= '0;
      r_flag_count   <= '0;
      r_reveal_count <= '0;
      r_lost         <= 1'b0;
      r_won          <= 1'b0;
      r_cur_row      <= '0;
      r_cur_col      <= '0;
      r_dir          <= '0;
    end else begin
      if (w_flag_en) begin
        r_flagged[w_cmd_idx] <= !r_flagged[w_cmd_idx];
        r_flag_count <= r_flagged[w_cmd_idx] ? r_flag_count - CNTW'(1)
                                             : r_flag_count + CNTW'(1);
      end
      if (w_rev_en) begin
        r_revealed[w_rev_idx] <= 1'b1;
        r_reveal_count        <= r_reveal_count + CNTW'(1);
      end
      if (w_lost_set) r_lost <= 1'b1;
      if (!r_lost && (r_reveal_count == WIN_CNT)) r_won <= 1'b1;
      if (r_state == ST_POP) begin
        r_cur_row <= w_top[RW+CW-1:CW];
        r_cur_col <= w_top[CW-1:0];
        r_dir     <= '0;
      end else if (r_state == ST_SCAN) begin
        r_dir <= r_dir + 3'd1;
      end
    end
  end

  assign o_flagged      = r_flagged;
  assign o_revealed     = r_revealed;
  assign o_flag_count   = r_flag_count;
  assign o_reveal_count = r_reveal_count;
  assign o_busy         = (r_state == ST_POP) || (r_state == ST_SCAN);
  assign o_lost         = r_lost;
  assign o_won          = r_won;

endmodule

// File: tb/tb_tile_reveal_engine.sv
// Bench for tile_reveal_engine: a 4x4 single-mine instance checked
// against a command-level board model, plus a 5x5 instance for
// out-of-range coordinates.
module tb_tile_reveal_engine;
  import minesweeper_pkg::*;

  logic clk;
  logic rst;

  // 4x4, one mine
  logic        a_valid, a_op, a_ready, a_busy, a_lost, a_won;
  logic [1:0]  a_row, a_col;
  logic [15:0] a_mine, a_flagged, a_revealed;
  logic [63:0] a_adj;
  logic [4:0]  a_fcnt, a_rcnt;

  // 5x5, default parameters
  logic        b_valid, b_op, b_ready, b_busy, b_lost, b_won;
  logic [2:0]  b_row, b_col;
  logic [24:0] b_mine, b_flagged, b_revealed;
  logic [99:0] b_adj;
  logic [4:0]  b_fcnt, b_rcnt;

  int checks = 0;
  int errors = 0;

  // board model
  bit m_mine[16];
  int m_adj[16];
  bit e_flag[16];
  bit e_rev[16];
  bit e_lost, e_won;

  tile_reveal_engine #(.GRID_W(4), .GRID_H(4), .NUM_MINES(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(a_valid), .o_cmd_ready(a_ready),
    .i_cmd_op(a_op), .i_cmd_row(a_row), .i_cmd_col(a_col),
    .i_mine_map(a_mine), .i_adj_count(a_adj),
    .o_flagged(a_flagged), .o_revealed(a_revealed),
    .o_flag_count(a_fcnt), .o_reveal_count(a_rcnt),
    .o_busy(a_busy), .o_lost(a_lost), .o_won(a_won)
  );

  tile_reveal_engine u_b (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(b_valid), .o_cmd_ready(b_ready),
    .i_cmd_op(b_op), .i_cmd_row(b_row), .i_cmd_col(b_col),
    .i_mine_map(b_mine), .i_adj_count(b_adj),
    .o_flagged(b_flagged), .o_revealed(b_revealed),
    .o_flag_count(b_fcnt), .o_reveal_count(b_rcnt),
    .o_busy(b_busy), .o_lost(b_lost), .o_won(b_won)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      e_flag[i] = 1'b0;
      e_rev[i]  = 1'b0;
    end
    e_lost = 1'b0;
    e_won  = 1'b0;
  endtask

  task automatic load_board_a(input int mr, input int mc);
    int cnt, nr, nc;
    for (int i = 0; i < 16; i++) m_mine[i] = (i == mr * 4 + mc);
    for (int i = 0; i < 16; i++) begin
      cnt = 0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++) begin
          nr = i / 4 + dr;
          nc = i % 4 + dc;
          if ((dr != 0 || dc != 0) && nr >= 0 && nr < 4 && nc >= 0 && nc < 4)
            if (m_mine[nr * 4 + nc]) cnt++;
        end
      m_adj[i]        = cnt;
      a_adj[4*i +: 4] = 4'(cnt);
      a_mine[i]       = m_mine[i];
    end
  endtask

  // Board-level effect of one accepted command; returns how many tiles
  // get expanded (every revealed, unflagged zero tile in the region).
  function automatic int model_cmd(input bit op, input int r, input int c);
    int q[$];
    int k, i, t, nr, nc, j;
    k = 0;
    if (r >= 4 || c >= 4) return 0;
    i = r * 4 + c;
    if (op == OP_FLAG) begin
      if (!e_rev[i]) e_flag[i] = !e_flag[i];
      return 0;
    end
    if (e_rev[i] || e_flag[i]) return 0;
    e_rev[i] = 1'b1;
    if (m_mine[i]) begin
      e_lost = 1'b1;
      return 0;
    end
    if (m_adj[i] != 0) return 0;
    q.push_back(i);
    while (q.size() > 0) begin
      t = q.pop_front();
      k++;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++) begin
          nr = t / 4 + dr;
          nc = t % 4 + dc;
          if ((dr != 0 || dc != 0) && nr >= 0 && nr < 4 && nc >= 0 && nc < 4) begin
            j = nr * 4 + nc;
            if (!e_rev[j] && !e_flag[j]) begin
              e_rev[j] = 1'b1;
              if (m_adj[j] == 0) q.push_back(j);
            end
          end
        end
    end
    return k;
  endfunction

  function automatic logic [63:0] pack_flag();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i] = e_flag[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_rev();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i] = e_rev[i];
    return v;
  endfunction

  function automatic int ones(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "/flagged"},  64'(a_flagged),  pack_flag());
    check({tag, "/revealed"}, 64'(a_revealed), pack_rev());
    check({tag, "/fcnt"},     64'(a_fcnt),     64'(ones(pack_flag())));
    check({tag, "/rcnt"},     64'(a_rcnt),     64'(ones(pack_rev())));
    check({tag, "/lost"},     64'(a_lost),     64'(e_lost));
    check({tag, "/won"},      64'(a_won),      64'(e_won));
    check({tag, "/ready"},    64'(a_ready),    64'(!e_lost && !e_won));
    check({tag, "/busy"},     64'(a_busy),     64'(0));
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic send_a(input bit op, input int r, input int c, input string tag,
                        output int busy_n);
    int k, n;
    n = 0;
    while (!a_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "/ready_in"}, 64'(a_ready), 64'(1));
    a_valid = 1'b1;
    a_op    = op;
    a_row   = 2'(r);
    a_col   = 2'(c);
    tick();
    a_valid = 1'b0;
    k = model_cmd(op, r, c);
    if (op == OP_FLAG) check({tag, "/flag_n1"}, 64'(a_flagged), pack_flag());
    if (k > 0) check({tag, "/busy_n1"}, 64'(a_busy), 64'(1));
    if (e_lost) begin
      check({tag, "/lost_n1"}, 64'(a_lost), 64'(1));
      check({tag, "/ready_n1"}, 64'(a_ready), 64'(0));
    end
    busy_n = 0;
    while (a_busy && busy_n < 400) begin
      tick();
      busy_n++;
    end
    check({tag, "/busy_cycles"}, 64'(busy_n), 64'(9 * k));
    tick();
    if (!e_lost && ones(pack_rev()) == 15) e_won = 1'b1;
    check_state(tag);
  endtask

  task automatic send_b(input bit op, input int r, input int c);
    b_valid = 1'b1;
    b_op    = op;
    b_row   = 3'(r);
    b_col   = 3'(c);
    tick();
    b_valid = 1'b0;
  endtask

  initial begin
    int bn, n;
    logic [63:0] one;
    one = 64'd1;
    rst = 1'b1;
    a_valid = 1'b0; a_op = 1'b0; a_row = '0; a_col = '0;
    a_mine = '0; a_adj = '0;
    b_valid = 1'b0; b_op = 1'b0; b_row = '0; b_col = '0;
    b_mine = '0;
    b_adj  = {25{4'h1}};

    // Directed: mine at (3,3)
    load_board_a(3, 3);
    do_reset();
    check_state("reset");

    send_a(OP_FLAG, 1, 1, "flag11_set", bn);
    check("flag11_bit_set", 64'(a_flagged[5]), 64'(1));
    send_a(OP_FLAG, 1, 1, "flag11_clr", bn);
    check("flag11_bit_clr", 64'(a_fcnt), 64'(0));

    // flood with a flag in the zero region
    send_a(OP_FLAG, 1, 1, "wall_flag", bn);
    send_a(OP_REVEAL, 0, 0, "flood_wall", bn);
    check("wall_unrevealed", 64'(a_revealed[5]), 64'(0));
    check("wall_rcnt14", 64'(a_rcnt), 64'(14));
    check("wall_busy99", 64'(bn), 64'(99));
    send_a(OP_FLAG, 0, 0, "flag_on_revealed", bn);
    send_a(OP_FLAG, 1, 1, "unflag", bn);
    send_a(OP_REVEAL, 1, 1, "reveal_last", bn);
    check("reveal_last_won", 64'(a_won), 64'(1));

    // full flood from the corner
    do_reset();
    check_state("reset2");
    send_a(OP_REVEAL, 0, 0, "full_flood", bn);
    check("full_flood_busy108", 64'(bn), 64'(108));
    check("full_flood_rcnt15", 64'(a_rcnt), 64'(15));
    check("full_flood_won", 64'(a_won), 64'(1));

    // mine reveal, then a held command must be ignored
    do_reset();
    send_a(OP_REVEAL, 3, 3, "mine", bn);
    a_valid = 1'b1; a_op = OP_FLAG; a_row = 2'd0; a_col = 2'd0;
    tick(); tick(); tick();
    a_valid = 1'b0;
    check("after_lost_flag_ignored", 64'(a_flagged), 64'(0));
    check("after_lost_ready", 64'(a_ready), 64'(0));

    // reset in the middle of a flood
    do_reset();
    a_valid = 1'b1; a_op = OP_REVEAL; a_row = 2'd0; a_col = 2'd0;
    tick();
    a_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check("midflood_busy", 64'(a_busy), 64'(1));
    rst = 1'b1;
    tick();
    model_clear();
    check_state("midflood_rst");
    rst = 1'b0;
    send_a(OP_REVEAL, 0, 0, "after_rst", bn);
    check("after_rst_busy108", 64'(bn), 64'(108));

    // 5x5 instance: out-of-range coordinates are consumed silently
    do_reset();
    check("b_reset_ready", 64'(b_ready), 64'(1));
    send_b(OP_FLAG, 5, 2);
    check("b_oor_flag_ready", 64'(b_ready), 64'(1));
    check("b_oor_flag_flags", 64'(b_flagged), 64'(0));
    check("b_oor_flag_fcnt", 64'(b_fcnt), 64'(0));
    send_b(OP_REVEAL, 6, 1);
    check("b_oor_rev_row", 64'(b_revealed), 64'(0));
    check("b_oor_rev_busy", 64'(b_busy), 64'(0));
    send_b(OP_REVEAL, 2, 7);
    check("b_oor_rev_col", 64'(b_rcnt), 64'(0));
    send_b(OP_FLAG, 4, 4);
    check("b_flag44", 64'(b_flagged), one << 24);
    send_b(OP_REVEAL, 2, 2);
    check("b_rev22", 64'(b_revealed), one << 12);
    check("b_rev22_ready", 64'(b_ready), 64'(1));

    // Randomized games against the board model
    for (int ep = 0; ep < 20; ep++) begin
      load_board_a($urandom_range(3), $urandom_range(3));
      do_reset();
      n = 0;
      while (!e_lost && !e_won && n < 20) begin
        send_a(bit'($urandom_range(1)), $urandom_range(3), $urandom_range(3),
               $sformatf("rnd%0d_%0d", ep, n), bn);
        n++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
